gpr_wr_arb: RTL
===============

# gpr_wr_arb

Write-port arbiter for the general-purpose register file. It shares the single GPR write port among three sources: the core's execute/writeback stage, the multi-cycle divider, and the debug/bus master. The execute stage has priority, but a starvation guard forces a waiting low-priority requester through within a bounded number of cycles. It sits between those three sources and the register file write inputs (`we_i`/`waddr_i`/`wdata_i`).

## Interface

Parameters:
- `ADDR_W`, default 5: GPR address width; 4 when the base ISA has 16 registers.
- `DATA_W`, default 32: register data width.
- `STARVE_MAX`, default 4: count of consecutive waiting cycles at which a div/dbg requester is forced through.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ex_we_i` in 1: execute-stage write request.
- `ex_waddr_i` in ADDR_W: execute-stage write address.
- `ex_wdata_i` in DATA_W: execute-stage write data.
- `ex_stall_o` out 1: execute-stage write blocked this cycle; the core holds its ex inputs.
- `div_valid_i` in 1: divider write request.
- `div_ready_o` out 1: divider write accepted.
- `div_waddr_i` in ADDR_W: divider write address.
- `div_wdata_i` in DATA_W: divider write data.
- `dbg_valid_i` in 1: debug/bus write request.
- `dbg_ready_o` out 1: debug/bus write accepted.
- `dbg_waddr_i` in ADDR_W: debug/bus write address.
- `dbg_wdata_i` in DATA_W: debug/bus write data.
- `we_o` out 1: write enable to the register file.
- `waddr_o` out ADDR_W: write address to the register file.
- `wdata_o` out DATA_W: write data to the register file.
- `grant_o` out 2: current grant; 0 none, 1 ex, 2 div, 3 dbg.

## Operation

**Grant priority (combinational, per cycle), highest first:**
1. A forced requester, i.e. one whose starvation count equals STARVE_MAX.
2. ex, when `ex_we_i` is high.
3. div and dbg, resolved by the round-robin pointer.

**Resolution rules:**
- If both div and dbg are forced, the round-robin pointer picks between them.
- Round-robin pointer: 1 bit; reset value selects div. After any div or dbg grant it points to the other requester.

**Handshake (div/dbg):**
- A transfer completes when valid && ready.
- `ready_o` is high only for the granted requester, and only while its valid is high.
- A requester holds address and data stable from valid until acceptance.
- A requester may not withdraw valid before acceptance. If it does, its counter clears.

**Starvation counters (one each for div and dbg):**
- Increment on each cycle where valid is high and no grant is given; saturate at STARVE_MAX.
- Clear on grant, or when valid is low.

**Execute-stage stall:**
- `ex_stall_o` = `ex_we_i` && (grant is div or dbg).
- ex has no handshake; the core repeats its request the next cycle.

**Output mux:**
- `waddr_o` and `wdata_o` follow the granted source; they are 0 when there is no grant.
- `we_o` = granted && waddr ≠ 0. A write to x0 still completes its handshake (or ex proceeds), but no write is issued.

**Reset:**
- While `rst_n` is low, all grants are suppressed: `we_o`, `ready_o`s, and `ex_stall_o` are 0; `grant_o` is 0; `waddr_o` and `wdata_o` are 0.
- Counters and pointer go to 0 / div immediately.
- Reset asserted mid-wait discards the pending counts. Requesters re-present after reset.

## Timing

- Grant, ready, stall and the write-port outputs are combinational from the inputs and state. Zero added latency: the register file captures on the same edge as the handshake.
- Counter and pointer update on the rising edge of `clk`.
- Starvation bound: a div/dbg request that is valid from cycle 0 while ex writes every cycle is granted no later than cycle STARVE_MAX.
- When both div and dbg starve simultaneously, the loser is granted no later than one cycle after the winner.
- Paths from `ex_we_i` to `div_ready_o`/`dbg_ready_o` are combinational. Requesters must not make valid depend on ready.

## Structure

- Shared include `defines.v` holds:
  - the grant encodings `GNT_NONE`, `GNT_EX`, `GNT_DIV`, `GNT_DBG`;
  - `RegAddrBus`/`RegBus` widths, reused for the port widths.
- One sub-module, `starve_ctr`: saturating counter with inc/clr inputs and a `forced_o` output. It is instantiated for div and for dbg.
- Top level contains the priority/round-robin logic and the output mux.

## Test plan

- **Idle after reset:** no requests → `we_o`=0, `grant_o`=0, `ex_stall_o`=0, readies 0.
- **ex plus div, ex priority:** `ex_we_i`=1 with addr 5, data 0x11 and `div_valid_i`=1 with addr 6, data 0x22 in the same cycle → grant ex, `waddr_o`=5, `div_ready_o`=0. Next cycle, with ex idle → grant div, `waddr_o`=6.
- **Starvation:** ex writes every cycle and dbg is valid from cycle 0, STARVE_MAX=4 → cycle 4 has `grant_o`=3, `dbg_ready_o`=1, `ex_stall_o`=1. In cycle 5, ex is granted again.
- **Round-robin:** div and dbg both valid continuously, ex idle → grants alternate div, dbg, div, dbg, starting with div after reset.
- **x0 write:** `dbg_valid_i` with addr 0, data 0xFFFF → `dbg_ready_o`=1 and `we_o`=0 in the same cycle.
- **Reset mid-wait:** dbg counter at 3, then `rst_n` pulsed low → all outputs 0 during reset. Afterwards dbg is forced only after 4 more blocked cycles.

Source files
------------

// File: rtl/gpr_wr_arb_pkg.sv
// Shared definitions for the GPR write-port arbiter: grant encodings,
// default port widths and the round-robin pick helper.
package gpr_wr_arb_pkg;

   // Default register-file address and data widths.
   localparam int unsigned RegAddrBus = 5;
   localparam int unsigned RegBus     = 32;

   // Grant encodings, also the values driven on grant_o.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_EX   = 2'd1,
      GNT_DIV  = 2'd2,
      GNT_DBG  = 2'd3
   } gnt_e;

   // Resolve between the two low-priority requesters. When both are asking,
   // prefer_dbg (the round-robin pointer) decides who wins.
   function automatic gnt_e pick_low(input logic div_req,
                                     input logic dbg_req,
                                     input logic prefer_dbg);
      gnt_e res;
      if (div_req && dbg_req) begin
         res = prefer_dbg ? GNT_DBG : GNT_DIV;
      end else if (div_req) begin
         res = GNT_DIV;
      end else if (dbg_req) begin
         res = GNT_DBG;
      end else begin
         res = GNT_NONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/gpr_wr_arb_starve_ctr.sv
// Saturating wait counter for one low-priority write requester. forced_o
// rises once the requester has been passed over MAX consecutive cycles.
module starve_ctr #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic forced_o
);

   localparam int unsigned CW = $clog2(MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over increment, and the count holds at MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CW'(MAX))) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register; reset discards any accumulated wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign forced_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/gpr_wr_arb.sv
// GPR write-port arbiter: shares the single register-file write port between
// the execute stage (priority), the divider and the debug/bus master, with a
// starvation guard that forces a waiting div/dbg write through.
module gpr_wr_arb
   import gpr_wr_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = RegAddrBus,
   parameter int unsigned DATA_W     = RegBus,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_we_i,
   input  logic [ADDR_W-1:0] ex_waddr_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   output logic              ex_stall_o,
   input  logic              div_valid_i,
   output logic              div_ready_o,
   input  logic [ADDR_W-1:0] div_waddr_i,
   input  logic [DATA_W-1:0] div_wdata_i,
   input  logic              dbg_valid_i,
   output logic              dbg_ready_o,
   input  logic [ADDR_W-1:0] dbg_waddr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [1:0]        grant_o
);

   gnt_e              gnt_s;
   logic              rr_q;
   logic              rr_d;
   logic              div_sat_s;
   logic              dbg_sat_s;
   logic              div_forced_s;
   logic              dbg_forced_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [DATA_W-1:0] wdata_s;

   // A saturated counter only forces a grant while the request is still up;
   // a withdrawn request clears its counter on the next edge.
   assign div_forced_s = div_valid_i & div_sat_s;
   assign dbg_forced_s = dbg_valid_i & dbg_sat_s;

   // Grant selection: forced div/dbg, then ex, then round-robin div/dbg.
   // Nothing is granted while reset is asserted.
   always_comb begin
      gnt_s = GNT_NONE;
      if (!rst_n) begin
         gnt_s = GNT_NONE;
      end else if (div_forced_s || dbg_forced_s) begin
         gnt_s = pick_low(div_forced_s, dbg_forced_s, rr_q);
      end else if (ex_we_i) begin
         gnt_s = GNT_EX;
      end else begin
         gnt_s = pick_low(div_valid_i, dbg_valid_i, rr_q);
      end
   end

   // Round-robin pointer moves to the other requester after a div/dbg grant.
   always_comb begin
      rr_d = rr_q;
      case (gnt_s)
         GNT_DIV: rr_d = 1'b1;
         GNT_DBG: rr_d = 1'b0;
         default: rr_d = rr_q;
      endcase
   end

   // Pointer register; reset value favours the divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   starve_ctr #(.MAX(STARVE_MAX)) u_div_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (div_valid_i & (gnt_s != GNT_DIV)),
      .clr_i    (~div_valid_i | (gnt_s == GNT_DIV)),
      .forced_o (div_sat_s)
   );

   starve_ctr #(.MAX(STARVE_MAX)) u_dbg_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (dbg_valid_i & (gnt_s != GNT_DBG)),
      .clr_i    (~dbg_valid_i | (gnt_s == GNT_DBG)),
      .forced_o (dbg_sat_s)
   );

   // Write-port mux: steer the granted source, drive zeros when idle.
   always_comb begin
      waddr_s = '0;
      wdata_s = '0;
      case (gnt_s)
         GNT_EX: begin
            waddr_s = ex_waddr_i;
            wdata_s = ex_wdata_i;
         end
         GNT_DIV: begin
            waddr_s = div_waddr_i;
            wdata_s = div_wdata_i;
         end
         GNT_DBG: begin
            waddr_s = dbg_waddr_i;
            wdata_s = dbg_wdata_i;
         end
         default: begin
            waddr_s = '0;
            wdata_s = '0;
         end
      endcase
   end

   // x0 is hardwired: the handshake completes but no write is issued.
   assign we_o        = (gnt_s != GNT_NONE) && (waddr_s != '0);
   assign waddr_o     = waddr_s;
   assign wdata_o     = wdata_s;
   assign grant_o     = gnt_s;
   assign div_ready_o = (gnt_s == GNT_DIV);
   assign dbg_ready_o = (gnt_s == GNT_DBG);
   assign ex_stall_o  = ex_we_i && ((gnt_s == GNT_DIV) || (gnt_s == GNT_DBG));

endmodule
